// File: rtl/trig_window_writer.sv
// trig_window_writer: on a trigger edge, writes a framed event (3-word header + WIN_LEN tagged samples) to a FIFO
module trig_window_writer #(
  parameter int P_WIDTH = 14,
  parameter int WIN_LEN = 64,
  parameter int HOLDOFF = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ro_en,
  input  logic               trig,
  input  logic [P_WIDTH-1:0] din,
  input  logic               fifo_afull,
  input  logic               fifo_full,
  output logic               fifo_wrreq,
  output logic [P_WIDTH+1:0] fifo_data,
  output logic               busy,
  output logic [15:0]        evt_cnt,
  output logic [15:0]        drop_cnt,
  output logic               overflow
);
  typedef enum logic [1:0] {IDLE, HDR, DATA, HOLD} state_t;
  state_t             state_q, state_d;
  logic [9:0]         cnt_q, cnt_d;
  logic [27:0]        ts_q, ts_d, ts_lat_q, ts_lat_d;
  logic               trig_q, trig_e, accept, reject;
  logic [P_WIDTH-1:0] dl_q [3];
  logic               wr_q, wr_d, ovf_q, ovf_d;
  logic [P_WIDTH+1:0] data_q, data_d;
  logic [15:0]        evt_q, evt_d, drop_q, drop_d;
  assign trig_e   = trig & ~trig_q;
  assign accept   = state_q == IDLE && trig_e && ro_en && !fifo_afull;
  assign reject   = state_q == IDLE && trig_e && ro_en && fifo_afull;
  assign ts_d     = ts_q + 28'd1;
  assign ts_lat_d = accept ? ts_q : ts_lat_q;
  assign evt_d    = evt_q + 16'(accept);
  assign drop_d   = drop_q + 16'(reject && drop_q != 16'hFFFF);
  assign ovf_d    = ovf_q | (wr_q & fifo_full);
  // Output word is registered, so each state computes the word for the next cycle;
  // the delay line tail lines up din(T) with the first DATA cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 10'd1;
    wr_d    = 1'b0;
    data_d  = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = HDR;
          wr_d    = 1'b1;
          data_d  = {2'b11, P_WIDTH'(evt_q[13:0])};
        end
      end
      HDR: begin
        wr_d   = 1'b1;
        data_d = cnt_q == 10'd0 ? {2'b10, P_WIDTH'(ts_lat_q[27:14])} :
                 cnt_q == 10'd1 ? {2'b10, P_WIDTH'(ts_lat_q[13:0])} :
                                  {WIN_LEN == 1 ? 2'b01 : 2'b00, dl_q[2]};
        if (cnt_q == 10'd2) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (cnt_q == 10'(WIN_LEN - 1)) begin
          state_d = HOLDOFF == 0 ? IDLE : HOLD;
          cnt_d   = '0;
        end else begin
          wr_d   = 1'b1;
          data_d = {cnt_q == 10'(WIN_LEN - 2) ? 2'b01 : 2'b00, dl_q[2]};
        end
      end
      HOLD: begin
        if (cnt_q == 10'(HOLDOFF - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ts_q     <= '0;
      ts_lat_q <= '0;
      trig_q   <= 1'b0;
      dl_q     <= '{default: '0};
      wr_q     <= 1'b0;
      data_q   <= '0;
      evt_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ts_q     <= ts_d;
      ts_lat_q <= ts_lat_d;
      trig_q   <= trig;
      dl_q[0]  <= din;
      dl_q[1]  <= dl_q[0];
      dl_q[2]  <= dl_q[1];
      wr_q     <= wr_d;
      data_q   <= data_d;
      evt_q    <= evt_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end
  assign fifo_wrreq = wr_q;
  assign fifo_data  = data_q;
  assign busy       = state_q != IDLE;
  assign evt_cnt    = evt_q;
  assign drop_cnt   = drop_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_trig_window_writer.sv
// tb_trig_window_writer: event-level model of the frame writer checked every cycle, plus directed literal checks
module tb_trig_window_writer;
  localparam int W = 8, H = 4;
  logic        clk = 1'b0, rst_n, ro_en, trig, fifo_afull, fifo_full;
  logic [13:0] din = '0;
  logic        fifo_wrreq, busy, overflow;
  logic [15:0] fifo_data, evt_cnt, drop_cnt;
  int          nerr = 0, nchk = 0;
  always #5 clk = ~clk;
  trig_window_writer #(.P_WIDTH(14), .WIN_LEN(W), .HOLDOFF(H)) dut (
    .clk(clk), .rst_n(rst_n), .ro_en(ro_en), .trig(trig), .din(din),
    .fifo_afull(fifo_afull), .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq),
    .fifo_data(fifo_data), .busy(busy), .evt_cnt(evt_cnt), .drop_cnt(drop_cnt),
    .overflow(overflow)
  );
  // Model: events are described by start cycle, number and timestamp; words derive from these.
  int          cyc = 0, mt = -100, free_at = 0;
  bit          act = 0, ptrig = 0, movf = 0;
  logic [27:0] mts = '0, ev_ts = '0;
  logic [15:0] mevt = '0, mdrop = '0;
  logic [13:0] ev_no = '0;
  logic [13:0] hist [4096];
  logic [15:0] wlog [$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  function automatic bit exp_wr(int m);
    return act && m - mt >= 1 && m - mt <= 3 + W;
  endfunction
  function automatic logic [15:0] exp_data(int m);
    int k = m - mt;
    if (k == 1) return {2'b11, ev_no};
    if (k == 2) return {2'b10, ev_ts[27:14]};
    if (k == 3) return {2'b10, ev_ts[13:0]};
    return {k == 3 + W ? 2'b01 : 2'b00, hist[(mt + k - 4) % 4096]};
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; mts = '0; mevt = '0; mdrop = '0; movf = 0;
      act = 0; ptrig = 0; free_at = 0; mt = -100;
    end else begin
      hist[cyc % 4096] = din;
      if (exp_wr(cyc) && fifo_full) movf = 1;
      if (trig && !ptrig && ro_en && cyc >= free_at) begin
        if (!fifo_afull) begin
          act = 1; mt = cyc; ev_no = mevt[13:0]; ev_ts = mts;
          mevt = mevt + 16'd1; free_at = cyc + 4 + W + H;
        end else if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
      end
      ptrig = trig;
      mts = mts + 28'd1;
      cyc++;
    end
  end
  always @(negedge clk) begin
    chk("wrreq", 32'(fifo_wrreq), 32'(exp_wr(cyc)));
    if (exp_wr(cyc)) chk("data", 32'(fifo_data), 32'(exp_data(cyc)));
    chk("busy", 32'(busy), 32'(act && cyc > mt && cyc < free_at));
    chk("evt_cnt", 32'(evt_cnt), 32'(mevt));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    chk("overflow", 32'(overflow), 32'(movf));
    if (fifo_wrreq) wlog.push_back(fifo_data);
  end
  initial forever begin
    @(negedge clk);
    din = 14'(cyc * 3 + 5);
  end
  task automatic pulse();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask
  task automatic wait_cyc(input int c);
    for (int i = 0; i < 200 && cyc < c; i++) @(negedge clk);
    chk("wait_cyc", 32'(cyc), 32'(c));
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int b;
    rst_n = 1'b0; ro_en = 1'b0; trig = 1'b0; fifo_afull = 1'b0; fifo_full = 1'b0;
    idle(3);
    chk("rst_evt", 32'(evt_cnt), 0);
    rst_n = 1'b1; ro_en = 1'b1;
    // first event at ts=100, din ramp 3*cycle+5
    idle(100);
    b = wlog.size(); pulse(); idle(20);
    chk("t1_len", 32'(wlog.size() - b), 11);
    chk("t1_h0", 32'(wlog[b]), 32'h C000);
    chk("t1_h1", 32'(wlog[b+1]), 32'h 8000);
    chk("t1_h2", 32'(wlog[b+2]), 32'h 8064);
    chk("t1_s0", 32'(wlog[b+3]), 32'h 0131);
    chk("t1_s7", 32'(wlog[b+10]), 32'h 4146);
    chk("t1_evt", 32'(evt_cnt), 1);
    // held trigger, then a pulse inside HOLD, then at the earliest re-arm cycle
    trig = 1'b1; idle(50); trig = 1'b0; idle(5);
    chk("t2_held_evt", 32'(evt_cnt), 2);
    pulse(); b = mt;
    wait_cyc(b + 13); pulse();
    wait_cyc(b + 16); pulse(); idle(20);
    chk("t2_evt", 32'(evt_cnt), 4);
    chk("t2_drop", 32'(drop_cnt), 0);
    // almost-full rejects
    fifo_afull = 1'b1; b = wlog.size();
    repeat (3) begin pulse(); idle(1); end
    fifo_afull = 1'b0; idle(2);
    chk("t3_drop", 32'(drop_cnt), 3);
    chk("t3_evt", 32'(evt_cnt), 4);
    chk("t3_len", 32'(wlog.size() - b), 0);
    // full during DATA
    b = wlog.size(); pulse(); wait_cyc(mt + 5);
    fifo_full = 1'b1; idle(4); fifo_full = 1'b0; idle(20);
    chk("t4_len", 32'(wlog.size() - b), 11);
    chk("t4_ovf", 32'(overflow), 1);
    idle(10);
    chk("t4_ovf_sticky", 32'(overflow), 1);
    // timestamp near wrap
    @(negedge clk);
    force dut.ts_q = 28'hFFFFFFE;
    #1 release dut.ts_q;
    mts = 28'hFFFFFFE;
    b = wlog.size(); pulse(); idle(20);
    chk("t5_h0", 32'(wlog[b]), 32'h C005);
    chk("t5_h1", 32'(wlog[b+1]), 32'h BFFF);
    chk("t5_h2", 32'(wlog[b+2]), 32'h BFFE);
    b = wlog.size(); pulse(); idle(20);
    chk("t5_wrap_h0", 32'(wlog[b]), 32'h C006);
    chk("t5_wrap_h1", 32'(wlog[b+1]), 32'h 8000);
    // asynchronous reset mid-event
    pulse(); wait_cyc(mt + 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_wrreq", 32'(fifo_wrreq), 0);
    chk("t6_data", 32'(fifo_data), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_evt", 32'(evt_cnt), 0);
    chk("t6_ovf", 32'(overflow), 0);
    @(negedge clk); rst_n = 1'b1; idle(5);
    b = wlog.size(); pulse(); idle(20);
    chk("t6_h0", 32'(wlog[b]), 32'h C000);
    chk("t6_evt_after", 32'(evt_cnt), 1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
